// File: rtl/idss_pkg.sv
// Shared types and constants for the input-data shift stage feeder.
// The channel count is fixed by the 2-bit LE_select of the stage.
package idss_pkg;

    localparam int unsigned NB_CHANNELS = 4;
    localparam int unsigned LE_SEL_W    = 2;
    localparam int unsigned PIXEL_W     = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        WINDOW,
        DONE
    } state_t;

endpackage

// File: rtl/idss_feeder.sv
// Upstream sequencer for the input-data shift stage: loads one column of NB_CHANNELS
// channel triplets, shifts it in, and announces complete 3x3x4 windows downstream.
module idss_feeder
    import idss_pkg::*;
#(
    parameter int unsigned IO_DATA_WIDTH     = 16,
    parameter int unsigned FEATURE_MAP_WIDTH = 1024,
    parameter int unsigned NB_CHANNELS       = 4,
    parameter int unsigned KERNEL_SIZE       = 3
) (
    input  logic                                 clk,
    input  logic                                 arst_in,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [IO_DATA_WIDTH-1:0]             in_row_1,
    input  logic [IO_DATA_WIDTH-1:0]             in_row_2,
    input  logic [IO_DATA_WIDTH-1:0]             in_row_3,
    output logic [IO_DATA_WIDTH-1:0]             row_1,
    output logic [IO_DATA_WIDTH-1:0]             row_2,
    output logic [IO_DATA_WIDTH-1:0]             row_3,
    output logic [LE_SEL_W-1:0]                  LE_select,
    output logic                                 shift,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0] win_col,
    output logic                                 busy,
    output logic                                 strip_done
);

    localparam int unsigned CW  = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned CCW = $clog2(FEATURE_MAP_WIDTH + 1);
    localparam int unsigned FW  = $clog2(KERNEL_SIZE + 1);

    state_t                 r_state;
    logic [LE_SEL_W-1:0]    r_ch_cnt;
    logic [LE_SEL_W-1:0]    r_le_select;
    logic [CCW-1:0]         r_col_cnt;
    logic [FW-1:0]          r_filled_cnt;
    logic [CW-1:0]          r_win_col;
    logic [IO_DATA_WIDTH-1:0] r_row_1;
    logic [IO_DATA_WIDTH-1:0] r_row_2;
    logic [IO_DATA_WIDTH-1:0] r_row_3;

    logic [CCW-1:0]         w_col_next;
    logic [FW-1:0]          w_filled_next;

    assign w_col_next    = r_col_cnt + CCW'(1);
    assign w_filled_next = (r_filled_cnt == FW'(KERNEL_SIZE)) ? r_filled_cnt
                                                               : r_filled_cnt + FW'(1);

    // Control outputs are pure decodes of the state register.
    assign in_ready   = (r_state == LOAD);
    assign shift      = (r_state == SHIFT);
    assign win_valid  = (r_state == WINDOW);
    assign busy       = (r_state != IDLE);
    assign strip_done = (r_state == DONE);

    assign row_1     = r_row_1;
    assign row_2     = r_row_2;
    assign row_3     = r_row_3;
    assign LE_select = r_le_select;
    assign win_col   = r_win_col;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_state      <= IDLE;
            r_ch_cnt     <= '0;
            r_le_select  <= '0;
            r_col_cnt    <= '0;
            r_filled_cnt <= '0;
            r_win_col    <= '0;
            r_row_1      <= '0;
            r_row_2      <= '0;
            r_row_3      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= LOAD;
                        r_ch_cnt     <= '0;
                        r_col_cnt    <= '0;
                        r_filled_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_row_1     <= in_row_1;
                        r_row_2     <= in_row_2;
                        r_row_3     <= in_row_3;
                        r_le_select <= r_ch_cnt;
                        if (r_ch_cnt == LE_SEL_W'(NB_CHANNELS - 1)) begin
                            r_ch_cnt <= '0;
                            r_state  <= SHIFT;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + LE_SEL_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    r_col_cnt    <= w_col_next;
                    r_filled_cnt <= w_filled_next;
                    if (w_filled_next == FW'(KERNEL_SIZE)) begin
                        // Left edge of the window that just became complete.
                        r_win_col <= CW'(w_col_next - CCW'(KERNEL_SIZE));
                        r_state   <= WINDOW;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                WINDOW: begin
                    if (win_ready) begin
                        r_state <= (r_col_cnt == CCW'(FEATURE_MAP_WIDTH)) ? DONE : LOAD;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
